// File: rtl/vector_pkg.sv
// vector_pkg: shared widths and the vector type used by the vector
// serializer and the vector buffer on the receive side.
package vector_pkg;

    localparam int VECTOR_W  = 8;
    localparam int BIT_IDX_W = 3;

    typedef logic [VECTOR_W-1:0] vector_t;

endpackage : vector_pkg

// File: rtl/vector_ring.sv
// vector_ring: ring buffer of whole vectors with producer/consumer pointers
// and an occupancy count. Slots are freed only when the consumer pops.
module vector_ring
    import vector_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    wr_en,
    input  vector_t wr_data,
    input  logic    rd_pop,
    output vector_t rd_data,
    output logic    full,
    output logic    empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    vector_t         mem [DEPTH];
    logic [PW-1:0]   prod;
    logic [PW-1:0]   cons;
    logic [CW-1:0]   count;
    logic            do_wr;
    logic            do_rd;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign rd_data = mem[cons];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_pop && !empty;

    // Storage write; contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[prod] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod  <= '0;
            cons  <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                prod <= prod + PW'(1);
            end
            if (do_rd) begin
                cons <= cons + PW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : vector_ring

// File: rtl/vector_serializer.sv
// vector_serializer: accepts 8-bit vectors over valid/ready, stores them in a
// ring and serves them one registered bit per request.
// Build option: define VECTOR_SERIALIZER_LSB_FIRST_EN to serve bits LSB-first
// instead of the default MSB-first order.
module vector_serializer
    import vector_pkg::*;
#(
    parameter int nb_vectors = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [VECTOR_W-1:0] vector,
    input  logic                vector_valid,
    output logic                vector_ready,
    input  logic                bit_req,
    output logic                output_bit,
    output logic                bit_valid,
    output logic                empty,
    output logic                full
);

    localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(VECTOR_W - 1);

    vector_t              rd_data;
    logic [BIT_IDX_W-1:0] idx;
    logic                 ring_full;
    logic                 ring_empty;
    logic                 wr_en;
    logic                 serve;
    logic                 pop;
    logic                 sel_bit;

    assign full         = ring_full;
    assign empty        = ring_empty;
    assign vector_ready = !ring_full;
    assign wr_en        = vector_valid && !ring_full;
    assign serve        = bit_req && !ring_empty;
    assign pop          = serve && (idx == LAST_IDX);

    vector_ring #(
        .DEPTH (nb_vectors)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (vector),
        .rd_pop  (pop),
        .rd_data (rd_data),
        .full    (ring_full),
        .empty   (ring_empty)
    );

    // Pick the bit of the oldest vector that the current index points at.
    always_comb begin
        sel_bit = 1'b0;
`ifdef VECTOR_SERIALIZER_LSB_FIRST_EN
        sel_bit = rd_data[idx];
`else
        sel_bit = rd_data[LAST_IDX - idx];
`endif
    end

    // Registered output stage and bit index; requests on an empty ring are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            output_bit <= 1'b0;
            bit_valid  <= 1'b0;
        end else begin
            output_bit <= 1'b0;
            bit_valid  <= 1'b0;
            if (serve) begin
                output_bit <= sel_bit;
                bit_valid  <= 1'b1;
                idx        <= idx + BIT_IDX_W'(1);
            end
        end
    end

endmodule : vector_serializer
